// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the bubble-MIPS core: sequences fetch/decode/execute/memory/writeback over a shared ALU and memory port.
// Optional feature macro ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of retiring as a NOP.
module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alucontrol,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             trap
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_WB_I     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SLL  = 6'd2;
    localparam logic [5:0] OP_SLT  = 6'd3;
    localparam logic [5:0] OP_SW   = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_BEQ  = 6'd6;
    localparam logic [5:0] OP_J    = 6'd7;
    localparam logic [5:0] OP_SUB  = 6'd8;
    localparam logic [5:0] OP_AND  = 6'd12;
    localparam logic [5:0] OP_OR   = 6'd13;
    localparam logic [5:0] OP_BNE  = 6'd16;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [5:0] opcode;
    logic       is_rtype;
    logic       is_itype;
    logic       is_mem;
    logic       is_branch;
    logic       is_jump;
    logic [2:0] r_alu_op;

    // Only the opcode field steers control; the operand fields feed the datapath.
    logic       unused_instr_fields;

    assign opcode              = instr[31:26];
    assign unused_instr_fields = ^instr[25:0];

    always_comb begin
        is_rtype  = 1'b0;
        is_itype  = 1'b0;
        is_mem    = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        r_alu_op  = ALU_ADD;
        case (opcode)
            OP_ADD:           is_rtype  = 1'b1;
            OP_SUB:  begin    is_rtype  = 1'b1; r_alu_op = ALU_SUB; end
            OP_SLT:  begin    is_rtype  = 1'b1; r_alu_op = ALU_SLT; end
            OP_AND:  begin    is_rtype  = 1'b1; r_alu_op = ALU_AND; end
            OP_OR:   begin    is_rtype  = 1'b1; r_alu_op = ALU_OR;  end
            OP_ADDI, OP_SLL:  is_itype  = 1'b1;
            OP_LW, OP_SW:     is_mem    = 1'b1;
            OP_BEQ, OP_BNE:   is_branch = 1'b1;
            OP_J:             is_jump   = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (instr_done) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Outputs are decoded from state; the handshake and branch enables are Mealy on mem_ack and zero.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alucontrol = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (is_rtype) begin
                    next_state = S_EXEC_R;
                end else if (is_itype) begin
                    next_state = S_EXEC_I;
                end else if (is_mem) begin
                    next_state = S_MEM_ADDR;
                end else if (is_branch) begin
                    next_state = S_BRANCH;
                end else if (is_jump) begin
                    next_state = S_JUMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    next_state = S_TRAP;
`else
                    instr_done = 1'b1;
                    next_state = S_FETCH;
`endif
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alucontrol = r_alu_op;
                next_state = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alucontrol = (opcode == OP_SLL) ? ALU_SLL : ALU_ADD;
                next_state = S_WB_I;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ack) begin
                    next_state = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ack) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alucontrol = ALU_SUB;
                pc_src     = 2'b01;
                pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                trap       = 1'b1;
                next_state = S_TRAP;
            end
`endif
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, corner-case sequences and randomized instructions against a phase-level model.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alucontrol;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             trap;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alucontrol(alucontrol), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .retired(retired), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alucontrol;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    ctrl_t act;
    assign act = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alucontrol, reg_write, reg_dst, mem_to_reg, instr_done, trap};

    // Phases of an instruction's life as seen from outside the controller.
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_WB = 3;
    localparam int PH_MEM = 4, PH_BRANCH = 5, PH_JUMP = 6, PH_TRAP = 7;
    localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BR = 4, CL_J = 5, CL_ILL = 6;

    typedef struct {
        int   ph;
        logic ack;
        logic z;
    } step_t;

    typedef struct {
        logic [5:0] op;
        int         fwait;
        int         mwait;
        int         zsel;
        int         cycles;
    } vec_t;

    step_t      seq[$];
    vec_t       vecs[14];
    logic [5:0] legal_ops[12];
    int         n_pass = 0;
    int         n_checks = 0;
    int         model_retired = 0;

    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'd0, 6'd3, 6'd8, 6'd12, 6'd13: return CL_R;
            6'd1, 6'd2:                     return CL_I;
            6'd5:                           return CL_LW;
            6'd4:                           return CL_SW;
            6'd6, 6'd16:                    return CL_BR;
            6'd7:                           return CL_J;
            default:                        return CL_ILL;
        endcase
    endfunction

    function automatic logic [2:0] r_op(input logic [5:0] op);
        case (op)
            6'd8:    return 3'b110;
            6'd3:    return 3'b011;
            6'd12:   return 3'b100;
            6'd13:   return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctrl_t expect_word(input int ph, input logic [5:0] op, input logic ack, input logic z);
        ctrl_t w;
        int    cl;
        w  = '0;
        cl = op_class(op);
        case (ph)
            PH_FETCH: begin
                w.mem_req = 1'b1; w.alu_src_b = 2'b01; w.ir_write = ack; w.pc_write = ack;
            end
            PH_DECODE: begin
                w.alu_src_b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
                if (cl == CL_ILL) w.instr_done = 1'b1;
`endif
            end
            PH_EXEC: begin
                w.alu_src_a = 1'b1;
                if (cl == CL_R) begin
                    w.alucontrol = r_op(op);
                end else begin
                    w.alu_src_b  = 2'b10;
                    w.alucontrol = (op == 6'd2) ? 3'b010 : 3'b000;
                end
            end
            PH_WB: begin
                w.reg_write = 1'b1; w.reg_dst = (cl == CL_R); w.mem_to_reg = (cl == CL_LW);
                w.instr_done = 1'b1;
            end
            PH_MEM: begin
                w.mem_req = 1'b1; w.i_or_d = 1'b1; w.mem_write = (cl == CL_SW);
                w.instr_done = (cl == CL_SW) && ack;
            end
            PH_BRANCH: begin
                w.alu_src_a = 1'b1; w.alucontrol = 3'b110; w.pc_src = 2'b01;
                w.pc_write = (op == 6'd6) ? z : ~z; w.instr_done = 1'b1;
            end
            PH_JUMP: begin
                w.pc_write = 1'b1; w.pc_src = 2'b10; w.instr_done = 1'b1;
            end
            PH_TRAP: w.trap = 1'b1;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic pick_z(input int zsel);
        return (zsel == 2) ? 1'($urandom % 2) : (zsel == 1);
    endfunction

    task automatic build_seq(input logic [5:0] op, input int fwait, input int mwait, input int zsel);
        int cl;
        cl = op_class(op);
        seq.delete();
        for (int i = 0; i < fwait; i++) seq.push_back('{PH_FETCH, 1'b0, pick_z(zsel)});
        seq.push_back('{PH_FETCH, 1'b1, pick_z(zsel)});
        seq.push_back('{PH_DECODE, 1'($urandom % 2), pick_z(zsel)});
        case (cl)
            CL_R, CL_I: begin
                seq.push_back('{PH_EXEC, 1'($urandom % 2), pick_z(zsel)});
                seq.push_back('{PH_WB, 1'($urandom % 2), pick_z(zsel)});
            end
            CL_LW, CL_SW: begin
                seq.push_back('{PH_EXEC, 1'($urandom % 2), pick_z(zsel)});
                for (int i = 0; i < mwait; i++) seq.push_back('{PH_MEM, 1'b0, pick_z(zsel)});
                seq.push_back('{PH_MEM, 1'b1, pick_z(zsel)});
                if (cl == CL_LW) seq.push_back('{PH_WB, 1'($urandom % 2), pick_z(zsel)});
            end
            CL_BR: seq.push_back('{PH_BRANCH, 1'($urandom % 2), pick_z(zsel)});
            CL_J:  seq.push_back('{PH_JUMP, 1'($urandom % 2), pick_z(zsel)});
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) seq.push_back('{PH_TRAP, 1'($urandom % 2), pick_z(zsel)});
`endif
            end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic z);
        mem_ack = ack;
        zero    = z;
    endtask

    // Drives the first n steps of seq, one clock each, comparing every cycle at the falling edge.
    task automatic apply_seq(input logic [5:0] op, input int n, output int done_at);
        ctrl_t exp;
        done_at = -1;
        instr   = {op, 26'($urandom)};
        for (int k = 0; k < n; k++) begin
            applyStimulus(seq[k].ack, seq[k].z);
            @(negedge clk);
            exp = expect_word(seq[k].ph, op, seq[k].ack, seq[k].z);
            checkOutput($sformatf("ctrl op=%0d step=%0d", op, k), 32'(act), 32'(exp));
            if (act.instr_done && done_at < 0) done_at = k + 1;
            if (exp.instr_done) model_retired++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_reset();
        applyStimulus(1'b1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_outputs", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        model_retired = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'($urandom % 2));
        #1;
        checkOutput("reset_outputs", 32'(act), 32'd0);
        checkOutput("reset_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        release_reset();
    endtask

    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait, input int zsel, output int done_at);
        build_seq(op, fwait, mwait, zsel);
        apply_seq(op, seq.size(), done_at);
        checkOutput($sformatf("retired op=%0d", op), 32'(retired), 32'(model_retired % (1 << CNT_W)));
    endtask

    initial begin
        int         done_at;
        logic [5:0] op;

        // {opcode, fetch wait, memory wait, zero (2=random), cycles to retirement}
        vecs[0]  = '{6'd0,  0, 0, 2, 4};
        vecs[1]  = '{6'd5,  0, 3, 2, 8};
        vecs[2]  = '{6'd6,  0, 0, 1, 3};
        vecs[3]  = '{6'd16, 0, 0, 1, 3};
        vecs[4]  = '{6'd4,  0, 0, 2, 4};
        vecs[5]  = '{6'd7,  0, 0, 2, 3};
        vecs[6]  = '{6'd1,  2, 0, 2, 6};
        vecs[7]  = '{6'd2,  0, 0, 2, 4};
        vecs[8]  = '{6'd8,  0, 0, 2, 4};
        vecs[9]  = '{6'd12, 0, 0, 2, 4};
        vecs[10] = '{6'd13, 0, 0, 2, 4};
        vecs[11] = '{6'd3,  0, 0, 2, 4};
        vecs[12] = '{6'd4,  1, 2, 2, 7};
        vecs[13] = '{6'd6,  0, 0, 0, 3};
        legal_ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd12, 6'd13, 6'd16};

        rst_n   = 1'b1;
        instr   = 32'd0;
        mem_ack = 1'b0;
        zero    = 1'b0;
        #2;
        do_reset();

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].fwait, vecs[i].mwait, vecs[i].zsel, done_at);
            checkOutput($sformatf("cycles vec%0d", i), 32'(done_at), 32'(vecs[i].cycles));
        end

        // Illegal opcode 9.
        build_seq(6'd9, 0, 0, 2);
        apply_seq(6'd9, seq.size(), done_at);
`ifdef ILLEGAL_TRAP_EN
        checkOutput("trap_no_retire", 32'(done_at), 32'hffff_ffff);
        checkOutput("trap_retired", 32'(retired), 32'(model_retired % (1 << CNT_W)));
        do_reset();
`else
        checkOutput("illegal_nop_cycles", 32'(done_at), 32'd2);
        checkOutput("illegal_retired", 32'(retired), 32'(model_retired % (1 << CNT_W)));
        run_instr(6'd0, 0, 0, 2, done_at);
        checkOutput("after_illegal_cycles", 32'(done_at), 32'd4);
`endif

        // Retired counter wraps from all-ones to zero.
        do_reset();
        for (int i = 0; i < 15; i++) run_instr(6'd7, 0, 0, 2, done_at);
        checkOutput("retired_at_15", 32'(retired), 32'd15);
        run_instr(6'd7, 0, 0, 2, done_at);
        checkOutput("retired_wrap", 32'(retired), 32'd0);

        // Reset asserted in the middle of a load handshake.
        run_instr(6'd0, 0, 0, 2, done_at);
        build_seq(6'd5, 0, 3, 2);
        apply_seq(6'd5, 4, done_at);
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("mid_rd_req_high", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rd_req_drop", 32'(mem_req), 32'd0);
        checkOutput("mid_rd_outputs", 32'(act), 32'd0);
        checkOutput("mid_rd_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        release_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 10 == 0) begin
                do op = 6'($urandom % 64); while (op_class(op) != CL_ILL);
            end else begin
                op = legal_ops[$urandom % 12];
            end
            run_instr(op, int'($urandom % 3), int'($urandom % 4), 2, done_at);
`ifdef ILLEGAL_TRAP_EN
            if (op_class(op) == CL_ILL) do_reset();
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
